// File: rtl/teclado_emulador_pkg.sv
// Shared keypad-emulator definitions: key encodings, keypad position table,
// press-sequence states and the password packet type used elsewhere in the project.
package teclado_emulador_pkg;

    localparam int KEY_W      = 4;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [3:0] {
        KEY_0    = 4'h0,
        KEY_1    = 4'h1,
        KEY_2    = 4'h2,
        KEY_3    = 4'h3,
        KEY_4    = 4'h4,
        KEY_5    = 4'h5,
        KEY_6    = 4'h6,
        KEY_7    = 4'h7,
        KEY_8    = 4'h8,
        KEY_9    = 4'h9,
        KEY_A    = 4'hA,
        KEY_B    = 4'hB,
        KEY_C    = 4'hC,
        KEY_D    = 4'hD,
        KEY_STAR = 4'hE,
        KEY_HASH = 4'hF
    } key_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BNC_PRESS,
        ST_HOLD,
        ST_BNC_REL,
        ST_GAP
    } press_state_e;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    // Indexed by key code; each entry is {row, col} of that key on the 4x4 pad
    // laid out as "1 2 3 A" / "4 5 6 B" / "7 8 9 C" / "* 0 # D".
    localparam key_pos_t KEY_POS_LUT [16] = '{
        4'hD, 4'h0, 4'h1, 4'h2,
        4'h4, 4'h5, 4'h6, 4'h8,
        4'h9, 4'hA, 4'h3, 4'h7,
        4'hB, 4'hF, 4'hC, 4'hE
    };

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        logic [2:0] len;
    } senhaPac_t;

    function automatic key_pos_t key_pos(input logic [KEY_W-1:0] code);
        return KEY_POS_LUT[code];
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/teclado_emulador_if.sv
// Key submission handshake: a producer offers key_code with key_valid,
// the emulator accepts it when key_ready is high.
interface teclado_emulador_if;
    import teclado_emulador_pkg::*;

    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_ready;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready
    );

endinterface

// File: rtl/teclado_fifo.sv
// Small circular FIFO holding queued key codes; head is readable combinationally
// so the press FSM can take it in the same cycle it pops.
module teclado_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_push,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/teclado_emulador.sv
// Matrix keypad emulator: queued keys are replayed as a bouncing contact closure
// that a row-scanning decoder sees on its active-low column inputs.
module teclado_emulador
    import teclado_emulador_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50000,
    parameter int BOUNCE_CYCLES = 2000,
    parameter int BOUNCE_PERIOD = 250,
    parameter int GAP_CYCLES    = 50000
) (
    input  logic                clk,
    input  logic                rst,
    teclado_emulador_if.slave   key_if,
    input  logic [3:0]          lin_matriz,
    output logic [3:0]          col_matriz,
    output logic                pressed,
    output logic                busy,
    output logic                key_done
);

    localparam int MAX_LEN = max4(HOLD_CYCLES, BOUNCE_CYCLES, BOUNCE_PERIOD, GAP_CYCLES);
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] BNC_LAST  = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] PER_LAST  = CW'((BOUNCE_PERIOD > 0) ? BOUNCE_PERIOD - 1 : 0);

    press_state_e     r_state;
    press_state_e     w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic [CW-1:0]    r_tgl;
    logic [CW-1:0]    w_tgl_next;
    logic             r_contact;
    logic             w_contact_next;
    logic [KEY_W-1:0] r_cur_key;
    logic [KEY_W-1:0] w_cur_key_next;

    logic             w_pop;
    logic             w_key_done;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [KEY_W-1:0] w_fifo_head;
    key_pos_t         w_cur_pos;
    logic             w_row_hit;

    teclado_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_data  (key_if.key_code),
        .i_push  (key_if.key_valid),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign key_if.key_ready = !w_fifo_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_tgl     <= '0;
            r_contact <= 1'b0;
            r_cur_key <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_tgl     <= w_tgl_next;
            r_contact <= w_contact_next;
            r_cur_key <= w_cur_key_next;
        end
    end

    // r_cnt counts cycles spent in the current phase; r_tgl paces bounce toggles.
    // The contact level for the first cycle of each phase is set on the transition.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt + CW'(1);
        w_tgl_next     = r_tgl;
        w_contact_next = r_contact;
        w_cur_key_next = r_cur_key;
        w_pop          = 1'b0;
        w_key_done     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                w_tgl_next = '0;
                if (!w_fifo_empty) begin
                    w_pop          = 1'b1;
                    w_cur_key_next = w_fifo_head;
                    w_contact_next = 1'b1;
                    w_state_next   = (BOUNCE_CYCLES == 0) ? ST_HOLD : ST_BNC_PRESS;
                end
            end

            ST_BNC_PRESS, ST_BNC_REL: begin
                if (r_cnt == BNC_LAST) begin
                    w_cnt_next = '0;
                    w_tgl_next = '0;
                    if (r_state == ST_BNC_PRESS) begin
                        w_state_next   = ST_HOLD;
                        w_contact_next = 1'b1;
                    end else begin
                        w_state_next   = ST_GAP;
                        w_contact_next = 1'b0;
                    end
                end else if (r_tgl == PER_LAST) begin
                    w_tgl_next     = '0;
                    w_contact_next = !r_contact;
                end else begin
                    w_tgl_next = r_tgl + CW'(1);
                end
            end

            ST_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_next     = '0;
                    w_tgl_next     = '0;
                    w_contact_next = 1'b0;
                    w_state_next   = (BOUNCE_CYCLES == 0) ? ST_GAP : ST_BNC_REL;
                end
            end

            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_next   = '0;
                    w_key_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // The emulated switch only connects its column when its own row is being driven low.
    assign w_cur_pos = key_pos(r_cur_key);
    assign w_row_hit = r_contact && !lin_matriz[w_cur_pos.row];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign col_matriz[gi] = !(w_row_hit && (w_cur_pos.col == 2'(gi)));
        end
    endgenerate

    assign pressed  = r_contact;
    assign busy     = (r_state != ST_IDLE) || !w_fifo_empty;
    assign key_done = w_key_done;

endmodule

// File: tb/tb_teclado_emulador.sv
// Drives two emulators (with and without bounce) from one random/directed stimulus
// stream and compares every output each cycle against a timeline model of the keys.
module tb_teclado_emulador;

    localparam int H   = 8;
    localparam int PER = 1;
    localparam int G   = 3;
    localparam int BNC [2] = '{4, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tb_valid = 1'b0;
    logic [3:0] tb_code  = 4'h0;
    logic [3:0] lin_matriz = 4'hF;

    logic [3:0] col_a, col_b;
    logic       pressed_a, pressed_b, busy_a, busy_b, done_a, done_b;

    int n = 0;
    int tests = 0;
    int failed = 0;

    // Per-DUT model: key code, accepting edge and popping edge of every accepted key.
    logic [3:0] q_k [2][$];
    int         q_e [2][$];
    int         q_p [2][$];

    string layout [4] = '{"123A", "456B", "789C", "*0#D"};
    string key_chars  = "0123456789ABCD*#";

    teclado_emulador_if if_a ();
    teclado_emulador_if if_b ();

    assign if_a.key_code  = tb_code;
    assign if_a.key_valid = tb_valid;
    assign if_b.key_code  = tb_code;
    assign if_b.key_valid = tb_valid;

    teclado_emulador #(
        .HOLD_CYCLES   (H),
        .BOUNCE_CYCLES (4),
        .BOUNCE_PERIOD (PER),
        .GAP_CYCLES    (G)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .key_if     (if_a.slave),
        .lin_matriz (lin_matriz),
        .col_matriz (col_a),
        .pressed    (pressed_a),
        .busy       (busy_a),
        .key_done   (done_a)
    );

    teclado_emulador #(
        .HOLD_CYCLES   (H),
        .BOUNCE_CYCLES (0),
        .BOUNCE_PERIOD (PER),
        .GAP_CYCLES    (G)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .key_if     (if_b.slave),
        .lin_matriz (lin_matriz),
        .col_matriz (col_b),
        .pressed    (pressed_b),
        .busy       (busy_b),
        .key_done   (done_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int seq_len(input int d);
        return 2 * BNC[d] + H + G;
    endfunction

    function automatic int occ(input int d, input int t);
        int c = 0;
        for (int i = 0; i < q_e[d].size(); i++)
            if (q_e[d][i] <= t && t < q_p[d][i]) c++;
        return c;
    endfunction

    function automatic int active_idx(input int d, input int t);
        for (int i = 0; i < q_p[d].size(); i++)
            if (q_p[d][i] <= t && t < q_p[d][i] + seq_len(d)) return i;
        return -1;
    endfunction

    function automatic logic press_level(input int d, input int k);
        int b = BNC[d];
        int r = k;
        if (r < b) return ((r / PER) % 2) == 0;
        r -= b;
        if (r < H) return 1'b1;
        r -= H;
        if (r < b) return ((r / PER) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic key_place(input logic [3:0] code, output int row, output int col);
        byte ch = key_chars[code];
        row = 0;
        col = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (layout[r][c] == ch) begin
                    row = r;
                    col = c;
                end
    endtask

    task automatic model_push(input int d, input logic [3:0] code, input int e);
        int p = e + 1;
        int last;
        if (q_p[d].size() > 0) begin
            last = q_p[d][q_p[d].size() - 1] + seq_len(d) + 1;
            if (last > p) p = last;
        end
        q_k[d].push_back(code);
        q_e[d].push_back(e);
        q_p[d].push_back(p);
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            q_k[d].delete();
            q_e[d].delete();
            q_p[d].delete();
        end
    endtask

    task automatic check_dut(input int d, input logic [3:0] col, input logic pr,
                             input logic bs, input logic dn, input logic rd);
        int a = active_idx(d, n);
        int row, cl, k;
        logic       e_pr = 1'b0;
        logic       e_dn = 1'b0;
        logic [3:0] e_col = 4'hF;
        if (a >= 0) begin
            k    = n - q_p[d][a];
            e_pr = press_level(d, k);
            e_dn = (k == seq_len(d) - 1);
            key_place(q_k[d][a], row, cl);
            if (e_pr && !lin_matriz[row]) e_col[cl] = 1'b0;
        end
        check($sformatf("dut%0d c%0d col", d, n), {28'd0, col}, {28'd0, e_col});
        check($sformatf("dut%0d c%0d pressed", d, n), {31'd0, pr}, {31'd0, e_pr});
        check($sformatf("dut%0d c%0d busy", d, n), {31'd0, bs},
              {31'd0, (a >= 0) || (occ(d, n) > 0)});
        check($sformatf("dut%0d c%0d key_done", d, n), {31'd0, dn}, {31'd0, e_dn});
        check($sformatf("dut%0d c%0d key_ready", d, n), {31'd0, rd}, {31'd0, occ(d, n) < 4});
    endtask

    task automatic check_all();
        check_dut(0, col_a, pressed_a, busy_a, done_a, if_a.key_ready);
        check_dut(1, col_b, pressed_b, busy_b, done_b, if_b.key_ready);
        $display("[TB] cycle %0d valid=%0b code=%h lin=%b | a: col=%b p=%0b d=%0b | b: col=%b p=%0b d=%0b",
                 n, tb_valid, tb_code, lin_matriz, col_a, pressed_a, done_a, col_b, pressed_b, done_b);
    endtask

    task automatic tick(input logic v, input logic [3:0] code, input logic [3:0] lin);
        @(posedge clk);
        n++;
        for (int d = 0; d < 2; d++)
            if (tb_valid && rst && occ(d, n - 1) < 4) model_push(d, tb_code, n);
        #1;
        tb_valid   = v;
        tb_code    = code;
        lin_matriz = lin;
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input int cycles, input logic [3:0] lin);
        tb_valid = 1'b0;
        rst      = 1'b0;
        model_clear();
        #1;
        check_all();
        repeat (cycles) tick(1'b0, 4'h0, lin);
        rst = 1'b1;
    endtask

    function automatic logic [3:0] rand_lin();
        logic [3:0] one = 4'b0001;
        if ($urandom_range(0, 1) == 1) return ~(one << $urandom_range(0, 3));
        return 4'($urandom);
    endfunction

    initial begin
        int a;
        logic [3:0] one = 4'b0001;

        #1;
        check_all();
        repeat (3) tick(1'b0, 4'h0, 4'hF);
        rst = 1'b1;

        // Key 5 with row 1 held low.
        tick(1'b1, 4'h5, 4'b1101);
        repeat (25) tick(1'b0, 4'h0, 4'b1101);

        // Key 5 under a rotating row scan.
        tick(1'b1, 4'h5, 4'b1110);
        for (int i = 1; i < 26; i++) tick(1'b0, 4'h0, ~(one << (i % 4)));

        // Burst of consecutive keys to fill the queue and see one refused.
        for (int i = 0; i < 6; i++) tick(1'b1, 4'(i + 1), rand_lin());
        repeat (110) tick(1'b0, 4'h0, rand_lin());

        // '#' with row 3 held low.
        tick(1'b1, 4'hF, 4'b0111);
        repeat (25) tick(1'b0, 4'h0, 4'b0111);

        // Reset during the hold phase with two keys queued behind.
        tick(1'b1, 4'h7, 4'b1011);
        tick(1'b1, 4'h8, 4'b1011);
        tick(1'b1, 4'h9, 4'b1011);
        for (int i = 0; i < 60; i++) begin
            a = active_idx(0, n);
            if (a >= 0 && n - q_p[0][a] == BNC[0] + 2) break;
            tick(1'b0, 4'h0, 4'b1011);
        end
        do_reset(2, 4'b1011);
        repeat (30) tick(1'b0, 4'h0, 4'b1011);

        tick(1'b1, 4'hA, 4'b1110);
        repeat (25) tick(1'b0, 4'h0, 4'b1110);

        // Random traffic.
        for (int i = 0; i < 800; i++)
            tick($urandom_range(0, 3) == 0, 4'($urandom), rand_lin());
        repeat (120) tick(1'b0, 4'h0, rand_lin());

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
